// File: rtl/fmpadding_pkg.sv
// Shared definitions for the fmpadding_axi feature-map padder: register
// addresses, stream width helper and the run-time geometry record.
package fmpadding_pkg;

  localparam logic [2:0] ADDR_XON  = 3'd0;
  localparam logic [2:0] ADDR_XOFF = 3'd1;
  localparam logic [2:0] ADDR_XEND = 3'd2;
  localparam logic [2:0] ADDR_YON  = 3'd4;
  localparam logic [2:0] ADDR_YOFF = 3'd5;
  localparam logic [2:0] ADDR_YEND = 3'd6;

  // Geometry fields are carried zero-extended so one struct fits any counter width.
  localparam int GEOM_W = 32;

  typedef struct packed {
    logic [GEOM_W-1:0] xon;
    logic [GEOM_W-1:0] xoff;
    logic [GEOM_W-1:0] xend;
    logic [GEOM_W-1:0] yon;
    logic [GEOM_W-1:0] yoff;
    logic [GEOM_W-1:0] yend;
  } geom_t;

  function automatic int stream_bits(input int simd, input int elem_bits);
    return 8 * ((simd * elem_bits + 7) / 8);
  endfunction

endpackage

// File: rtl/fmpadding_axilite_regs.sv
// AXI4-Lite slave holding the padder geometry registers (not cleared by rst).
// Macro FMPADDING_READBACK_EN enables register read-back; otherwise RDATA is 0.
module fmpadding_axilite_regs
  import fmpadding_pkg::*;
#(
  parameter int unsigned XCOUNTER_BITS = 8,
  parameter int unsigned YCOUNTER_BITS = 8,
  parameter int unsigned INIT_XON      = 0,
  parameter int unsigned INIT_XOFF     = 0,
  parameter int unsigned INIT_XEND     = 0,
  parameter int unsigned INIT_YON      = 0,
  parameter int unsigned INIT_YOFF     = 0,
  parameter int unsigned INIT_YEND     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axilite_AWVALID,
  output logic        s_axilite_AWREADY,
  input  logic [2:0]  s_axilite_AWADDR,
  input  logic        s_axilite_WVALID,
  output logic        s_axilite_WREADY,
  input  logic [31:0] s_axilite_WDATA,
  input  logic [3:0]  s_axilite_WSTRB,
  output logic        s_axilite_BVALID,
  input  logic        s_axilite_BREADY,
  output logic [1:0]  s_axilite_BRESP,
  input  logic        s_axilite_ARVALID,
  output logic        s_axilite_ARREADY,
  input  logic [2:0]  s_axilite_ARADDR,
  output logic        s_axilite_RVALID,
  input  logic        s_axilite_RREADY,
  output logic [31:0] s_axilite_RDATA,
  output logic [1:0]  s_axilite_RRESP,
  output geom_t       geom
);

  logic        ready_q, aw_pend, w_pend, do_write;
  logic [2:0]  awaddr_q;
  logic [31:0] wdata_q;

  // Power-up values only; these survive rst by design.
  logic [XCOUNTER_BITS-1:0] xon_q  = XCOUNTER_BITS'(INIT_XON);
  logic [XCOUNTER_BITS-1:0] xoff_q = XCOUNTER_BITS'(INIT_XOFF);
  logic [XCOUNTER_BITS-1:0] xend_q = XCOUNTER_BITS'(INIT_XEND);
  logic [YCOUNTER_BITS-1:0] yon_q  = YCOUNTER_BITS'(INIT_YON);
  logic [YCOUNTER_BITS-1:0] yoff_q = YCOUNTER_BITS'(INIT_YOFF);
  logic [YCOUNTER_BITS-1:0] yend_q = YCOUNTER_BITS'(INIT_YEND);

  logic unused_in;
  assign unused_in = ^{s_axilite_WSTRB, wdata_q, s_axilite_ARADDR};

  assign s_axilite_AWREADY = ready_q & ~aw_pend & ~s_axilite_BVALID;
  assign s_axilite_WREADY  = ready_q & ~w_pend  & ~s_axilite_BVALID;
  assign s_axilite_ARREADY = ready_q & ~s_axilite_RVALID;
  assign s_axilite_BRESP   = 2'b00;
  assign s_axilite_RRESP   = 2'b00;
  assign do_write          = aw_pend & w_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q          <= 1'b0;
      aw_pend          <= 1'b0;
      w_pend           <= 1'b0;
      awaddr_q         <= '0;
      wdata_q          <= '0;
      s_axilite_BVALID <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (do_write) begin
        aw_pend          <= 1'b0;
        w_pend           <= 1'b0;
        s_axilite_BVALID <= 1'b1;
      end else begin
        if (s_axilite_AWVALID && s_axilite_AWREADY) begin
          aw_pend  <= 1'b1;
          awaddr_q <= s_axilite_AWADDR;
        end
        if (s_axilite_WVALID && s_axilite_WREADY) begin
          w_pend  <= 1'b1;
          wdata_q <= s_axilite_WDATA;
        end
        if (s_axilite_BVALID && s_axilite_BREADY) s_axilite_BVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      case (awaddr_q)
        ADDR_XON:  xon_q  <= wdata_q[XCOUNTER_BITS-1:0];
        ADDR_XOFF: xoff_q <= wdata_q[XCOUNTER_BITS-1:0];
        ADDR_XEND: xend_q <= wdata_q[XCOUNTER_BITS-1:0];
        ADDR_YON:  yon_q  <= wdata_q[YCOUNTER_BITS-1:0];
        ADDR_YOFF: yoff_q <= wdata_q[YCOUNTER_BITS-1:0];
        ADDR_YEND: yend_q <= wdata_q[YCOUNTER_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    geom      = '0;
    geom.xon  = GEOM_W'(xon_q);
    geom.xoff = GEOM_W'(xoff_q);
    geom.xend = GEOM_W'(xend_q);
    geom.yon  = GEOM_W'(yon_q);
    geom.yoff = GEOM_W'(yoff_q);
    geom.yend = GEOM_W'(yend_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_axilite_RVALID <= 1'b0;
    end else if (s_axilite_ARVALID && s_axilite_ARREADY) begin
      s_axilite_RVALID <= 1'b1;
    end else if (s_axilite_RVALID && s_axilite_RREADY) begin
      s_axilite_RVALID <= 1'b0;
    end
  end

`ifdef FMPADDING_READBACK_EN
  logic [31:0] rd_mux, rdata_q;

  always_comb begin
    rd_mux = '0;
    case (s_axilite_ARADDR)
      ADDR_XON:  rd_mux = 32'(xon_q);
      ADDR_XOFF: rd_mux = 32'(xoff_q);
      ADDR_XEND: rd_mux = 32'(xend_q);
      ADDR_YON:  rd_mux = 32'(yon_q);
      ADDR_YOFF: rd_mux = 32'(yoff_q);
      ADDR_YEND: rd_mux = 32'(yend_q);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else if (s_axilite_ARVALID && s_axilite_ARREADY) rdata_q <= rd_mux;
  end

  assign s_axilite_RDATA = rdata_q;
`else
  assign s_axilite_RDATA = '0;
`endif

endmodule

// File: rtl/fmpadding_axi.sv
// Streaming feature-map padder: zero border around an interior copied from
// s_axis, geometry over AXI4-Lite. Macro FMPADDING_READBACK_EN: register read-back.
module fmpadding_axi
  import fmpadding_pkg::*;
#(
  parameter int unsigned XCOUNTER_BITS = 8,
  parameter int unsigned YCOUNTER_BITS = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned SIMD          = 2,
  parameter int unsigned ELEM_BITS     = 4,
  parameter int unsigned INIT_XON      = 0,
  parameter int unsigned INIT_XOFF     = 0,
  parameter int unsigned INIT_XEND     = 0,
  parameter int unsigned INIT_YON      = 0,
  parameter int unsigned INIT_YOFF     = 0,
  parameter int unsigned INIT_YEND     = 0,
  localparam int unsigned STREAM_BITS  = stream_bits(SIMD, ELEM_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axilite_AWVALID,
  output logic                   s_axilite_AWREADY,
  input  logic [2:0]             s_axilite_AWADDR,
  input  logic                   s_axilite_WVALID,
  output logic                   s_axilite_WREADY,
  input  logic [31:0]            s_axilite_WDATA,
  input  logic [3:0]             s_axilite_WSTRB,
  output logic                   s_axilite_BVALID,
  input  logic                   s_axilite_BREADY,
  output logic [1:0]             s_axilite_BRESP,
  input  logic                   s_axilite_ARVALID,
  output logic                   s_axilite_ARREADY,
  input  logic [2:0]             s_axilite_ARADDR,
  output logic                   s_axilite_RVALID,
  input  logic                   s_axilite_RREADY,
  output logic [31:0]            s_axilite_RDATA,
  output logic [1:0]             s_axilite_RRESP,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);

  localparam int unsigned FOLD = NUM_CHANNELS / SIMD;
  localparam int unsigned FW   = (FOLD > 1) ? $clog2(FOLD) : 1;

  if (NUM_CHANNELS % SIMD != 0) begin : g_fold_check
    $error("fmpadding_axi: NUM_CHANNELS must be a multiple of SIMD");
  end

  geom_t geom_cfg, geom;
  logic [FW-1:0]            fold;
  logic [XCOUNTER_BITS-1:0] x;
  logic [YCOUNTER_BITS-1:0] y;
  logic interior, free, step, fold_last, x_last, y_last, at_start, load_geom;

  fmpadding_axilite_regs #(
    .XCOUNTER_BITS(XCOUNTER_BITS), .YCOUNTER_BITS(YCOUNTER_BITS),
    .INIT_XON(INIT_XON), .INIT_XOFF(INIT_XOFF), .INIT_XEND(INIT_XEND),
    .INIT_YON(INIT_YON), .INIT_YOFF(INIT_YOFF), .INIT_YEND(INIT_YEND)
  ) u_regs (
    .clk(clk), .rst(rst),
    .s_axilite_AWVALID(s_axilite_AWVALID), .s_axilite_AWREADY(s_axilite_AWREADY),
    .s_axilite_AWADDR(s_axilite_AWADDR),
    .s_axilite_WVALID(s_axilite_WVALID), .s_axilite_WREADY(s_axilite_WREADY),
    .s_axilite_WDATA(s_axilite_WDATA), .s_axilite_WSTRB(s_axilite_WSTRB),
    .s_axilite_BVALID(s_axilite_BVALID), .s_axilite_BREADY(s_axilite_BREADY),
    .s_axilite_BRESP(s_axilite_BRESP),
    .s_axilite_ARVALID(s_axilite_ARVALID), .s_axilite_ARREADY(s_axilite_ARREADY),
    .s_axilite_ARADDR(s_axilite_ARADDR),
    .s_axilite_RVALID(s_axilite_RVALID), .s_axilite_RREADY(s_axilite_RREADY),
    .s_axilite_RDATA(s_axilite_RDATA), .s_axilite_RRESP(s_axilite_RRESP),
    .geom(geom_cfg)
  );

  always_comb begin
    interior  = (GEOM_W'(x) >= geom.xon) && (GEOM_W'(x) < geom.xoff) &&
                (GEOM_W'(y) >= geom.yon) && (GEOM_W'(y) < geom.yoff);
    free      = rst && (!m_axis_tvalid || m_axis_tready);
    step      = free && (!interior || s_axis_tvalid);
    fold_last = (fold == FW'(FOLD - 1));
    x_last    = (GEOM_W'(x) == geom.xend);
    y_last    = (GEOM_W'(y) == geom.yend);
    at_start  = (fold == '0) && (x == '0) && (y == '0);
    // Reloading on the wrapping step lets the first beat of the next frame see fresh geometry.
    load_geom = !rst || at_start || (step && fold_last && x_last && y_last);
  end

  assign s_axis_tready = interior && free;

  always_ff @(posedge clk) begin
    if (load_geom) geom <= geom_cfg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fold <= '0;
      x    <= '0;
      y    <= '0;
    end else if (step) begin
      if (fold_last) begin
        fold <= '0;
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        fold <= fold + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (step) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= interior ? s_axis_tdata : '0;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmpadding_axi.sv
// Self-checking bench for fmpadding_axi: AXI-Lite ordering, padding geometry,
// backpressure, reset behaviour, against a loop-based frame model.
module tb_fmpadding_axi;

  localparam int FOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [2:0]  awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [2:0]  araddr = '0;
  logic        rvalid, rready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        s_tready, s_tvalid = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        m_tready = 1'b0, m_tvalid;
  logic [7:0]  m_tdata;

  int n_assert = 0;
  int n_fail   = 0;
  int b_count  = 0;
  logic [1:0] last_bresp = '0;
  bit saw_tready;
  logic [7:0] in_q[$], exp_q[$], got_q[$];

  always #5 clk = ~clk;

  fmpadding_axi #(
    .XCOUNTER_BITS(8), .YCOUNTER_BITS(8),
    .NUM_CHANNELS(4), .SIMD(2), .ELEM_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(awready), .s_axilite_AWADDR(awaddr),
    .s_axilite_WVALID(wvalid), .s_axilite_WREADY(wready),
    .s_axilite_WDATA(wdata), .s_axilite_WSTRB(wstrb),
    .s_axilite_BVALID(bvalid), .s_axilite_BREADY(bready), .s_axilite_BRESP(bresp),
    .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(arready), .s_axilite_ARADDR(araddr),
    .s_axilite_RVALID(rvalid), .s_axilite_RREADY(rready),
    .s_axilite_RDATA(rdata), .s_axilite_RRESP(rresp),
    .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata)
  );

  always @(negedge clk) begin
    if (bvalid && bready) begin
      b_count    <= b_count + 1;
      last_bresp <= bresp;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_aw(input logic [2:0] a);
    int k = 0;
    @(negedge clk); awvalid = 1'b1; awaddr = a;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int k = 0;
    @(negedge clk); wvalid = 1'b1; wdata = d;
    while (!wready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); wvalid = 1'b0;
  endtask

  // mode 0: AW and W together, 1: W first, 2: AW first
  task automatic axi_write(input logic [2:0] a, input logic [31:0] d, input int mode);
    int b0 = b_count;
    int k = 0;
    if (mode == 0) begin
      @(negedge clk); awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
      while (!(awready && wready) && k < 50) begin @(negedge clk); k++; end
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      send_w(d); send_aw(a);
    end else begin
      send_aw(a); send_w(d);
    end
    k = 0;
    while (b_count == b0 && k < 50) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    n_assert++;
    if (b_count != b0 + 1) begin
      n_fail++;
      $display("FAIL bvalid_pulses addr=%0d mode=%0d: got %0d required 1", a, mode, b_count - b0);
    end
    n_assert++;
    if (last_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL bresp addr=%0d: got %b required 00", a, last_bresp);
    end
  endtask

  task automatic axi_read(input logic [2:0] a, output logic [31:0] d);
    int k = 0;
    @(negedge clk); arvalid = 1'b1; araddr = a;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 50) begin @(negedge clk); k++; end
    d = rvalid ? rdata : 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic check_readback(input int v0, v1, v2, v4, v5, v6);
    logic [2:0]  addrs[6];
    int          vals[6];
    logic [31:0] d, req;
    addrs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    vals  = '{v0, v1, v2, v4, v5, v6};
    for (int i = 0; i < 6; i++) begin
      axi_read(addrs[i], d);
`ifdef FMPADDING_READBACK_EN
      req = 32'(vals[i]);
`else
      req = 32'd0;
`endif
      n_assert++;
      if (d !== req) begin
        n_fail++;
        $display("FAIL readback addr=%0d: got %h required %h", addrs[i], d, req);
      end
    end
  endtask

  // Reference: walk the frame in y, x, fold order; interior takes the next input.
  task automatic build_model(input int nframes, xon, xoff, xend, yon, yoff, yend);
    int k = 0;
    exp_q.delete();
    for (int fr = 0; fr < nframes; fr++)
      for (int yy = 0; yy <= yend; yy++)
        for (int xx = 0; xx <= xend; xx++)
          for (int f = 0; f < FOLD; f++)
            if (xx >= xon && xx < xoff && yy >= yon && yy < yoff) begin
              exp_q.push_back(in_q[k]);
              k++;
            end else begin
              exp_q.push_back(8'h00);
            end
  endtask

  task automatic run_stream(input int n_chk, input bit bp, output int cycles);
    int got_n = 0, in_i = 0, stall = 0, cyc = 0;
    bit fired = 0, prev_stall = 0;
    logic [7:0] prev_data = '0;
    saw_tready = 0;
    got_q.delete();
    while (got_n < n_chk && cyc < 4000) begin
      @(negedge clk);
      if (bp && stall > 0) begin
        m_tready = 1'b0; stall--;
      end else begin
        m_tready = 1'b1;
        if (bp && $urandom_range(0, 2) == 0) stall = $urandom_range(1, 3);
      end
      if (!s_tvalid || fired) begin
        s_tvalid = (in_i < in_q.size()) && (!bp || $urandom_range(0, 3) != 0);
        s_tdata  = (in_i < in_q.size()) ? in_q[in_i] : 8'h00;
      end
      #1;
      if (prev_stall) begin
        n_assert++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: got tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                   m_tvalid, m_tdata, prev_data);
        end
      end
      if (s_tready === 1'b1) saw_tready = 1;
      if (m_tvalid && m_tready) begin
        n_assert++;
        if (m_tdata !== exp_q[got_n]) begin
          n_fail++;
          $display("FAIL beat %0d: got %h required %h", got_n, m_tdata, exp_q[got_n]);
        end
        got_q.push_back(m_tdata);
        got_n++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      fired      = s_tvalid && s_tready;
      if (fired) in_i++;
      cyc++;
    end
    n_assert++;
    if (got_n != n_chk) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats required %0d", got_n, n_chk);
    end
    cycles = cyc;
    @(negedge clk); m_tready = 1'b0; s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++;
      $display("FAIL ready_in_reset: got %b required 000", {awready, wready, arready});
    end
    n_assert++;
    if ({m_tvalid, s_tready, bvalid, rvalid} !== 4'b0000 || m_tdata !== 8'h00) begin
      n_fail++;
      $display("FAIL outputs_in_reset: got v/r/b/rv=%b data=%h required 0000 data=00",
               {m_tvalid, s_tready, bvalid, rvalid}, m_tdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_axil_ordering();
    logic [31:0] d;
    axi_write(3'd0, 32'h0000_0102, 1);   // upper bits truncated away -> 2
    axi_write(3'd1, 32'd7, 0);
    axi_write(3'd2, 32'd9, 2);
    axi_write(3'd4, 32'd1, 0);
    axi_write(3'd5, 32'd5, 1);
    axi_write(3'd6, 32'd6, 2);
    axi_write(3'd3, 32'hFF, 0);
    check_readback(2, 7, 9, 1, 5, 6);
    axi_read(3'd3, d);
    n_assert++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL read_addr3: got %h required 0", d); end
    axi_read(3'd7, d);
    n_assert++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL read_addr7: got %h required 0", d); end
  endtask

  task automatic test_standard();
    int cyc, bad;
    logic [7:0] row1[20];
    logic [7:0] img2[6];
    row1 = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5,
             8'h6, 8'h7, 8'h8, 8'h9, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    img2 = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h28, 8'h29};
    pulse_reset();
    in_q.delete();
    for (int i = 0; i < 80; i++) in_q.push_back(8'(i));
    build_model(2, 2, 7, 9, 1, 5, 6);
    run_stream(280, 0, cyc);
    bad = 0;
    for (int i = 0; i < 20; i++) if (got_q[i] !== 8'h00) bad++;
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL row_y0: got %0d nonzero beats required 0", bad); end
    bad = 0;
    for (int i = 0; i < 20; i++) if (got_q[20 + i] !== row1[i]) bad++;
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL row_y1: got %0d wrong beats required 0", bad); end
    bad = 0;
    for (int i = 100; i < 140; i++) if (got_q[i] !== 8'h00) bad++;
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL rows_y5_y6: got %0d nonzero beats required 0", bad); end
    bad = 0;
    for (int i = 0; i < 6; i++) if (got_q[160 + i] !== img2[i]) bad++;
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL image2_row1: got %0d wrong beats required 0", bad); end
  endtask

  task automatic test_backpressure();
    int cyc;
    pulse_reset();
    check_readback(2, 7, 9, 1, 5, 6);
    in_q.delete();
    for (int i = 0; i < 80; i++) in_q.push_back(8'(i));
    build_model(2, 2, 7, 9, 1, 5, 6);
    run_stream(280, 1, cyc);
  endtask

  task automatic test_midframe_reset();
    int cyc;
    in_q.delete();
    for (int i = 0; i < 40; i++) in_q.push_back(8'($urandom_range(0, 255)));
    build_model(1, 2, 7, 9, 1, 5, 6);
    pulse_reset();
    run_stream(37, 1, cyc);
    pulse_reset();
    run_stream(140, 1, cyc);
  endtask

  task automatic test_all_padding();
    int cyc;
    axi_write(3'd0, 32'd0, 0);
    axi_write(3'd1, 32'd0, 0);
    axi_write(3'd2, 32'd3, 0);
    axi_write(3'd4, 32'd0, 0);
    axi_write(3'd5, 32'd2, 0);
    axi_write(3'd6, 32'd1, 0);
    pulse_reset();
    in_q.delete();
    build_model(2, 0, 0, 3, 0, 2, 1);
    run_stream(32, 1, cyc);
    n_assert++;
    if (saw_tready) begin n_fail++; $display("FAIL all_pad_tready: got 1 required 0"); end
  endtask

  task automatic test_no_padding();
    int cyc;
    axi_write(3'd1, 32'd4, 2);
    axi_write(3'd5, 32'd2, 1);
    pulse_reset();
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    build_model(1, 0, 4, 3, 0, 2, 1);
    run_stream(16, 0, cyc);
    n_assert++;
    if (cyc != 17) begin n_fail++; $display("FAIL no_pad_throughput: got %0d cycles required 17", cyc); end
  endtask

  initial begin
    test_reset();
    test_axil_ordering();
    test_standard();
    test_backpressure();
    test_midframe_reset();
    test_all_padding();
    test_no_padding();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
